// File: rtl/seg_pkg.sv
// Shared constants, slot state encoding and sizing helper for the 7-segment scan controller.
package seg_pkg;

  localparam logic [6:0] SEG_OFF    = 7'b0000000;
  localparam logic [3:0] BLANK_CODE = 4'hF;

  typedef enum logic {
    ST_BLANK,
    ST_SHOW
  } slot_state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg_slot_timer.sv
// Per-digit slot timer: BLANK for BLANK_CYCLES cycles, then SHOW until CLK_DIV-1.
// BLANK_CYCLES is expected to be at least 1 so the decoder gets a settle cycle.
module seg_slot_timer
  import seg_pkg::*;
#(
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  output logic slot_start,
  output logic show,
  output logic show_next,
  output logic slot_end
);

  localparam int CW = cnt_width(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  slot_state_e     state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;

  // NOTE: non-blocking assignments so every register samples pre-edge values,
  // independent of the order in which always_ff blocks are evaluated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_BLANK;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
    unique case (state)
      ST_BLANK: if (cnt == BLANK_LAST) state_nxt = ST_SHOW;
      ST_SHOW:  if (cnt == CNT_LAST)   state_nxt = ST_BLANK;
      default:  state_nxt = ST_BLANK;
    endcase
  end

  assign slot_start = (state == ST_BLANK) && (cnt == '0);
  assign show       = (state == ST_SHOW);
  assign show_next  = (state_nxt == ST_SHOW);
  assign slot_end   = show && (cnt == CNT_LAST);

endmodule

// File: rtl/seg_scan_controller.sv
// Time-multiplexed BCD scan of NUM_DIGITS common-cathode digits through one external
// decoder, with double-buffered frames, leading-zero blanking and anti-ghost guard.
module seg_scan_controller
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_bcd,
  input  logic                    blank_lz,
  output logic [3:0]              dec_bcd,
  input  logic [6:0]              dec_seg,
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_done
);

  localparam int FW = 4 * NUM_DIGITS;
  localparam int IW = cnt_width(NUM_DIGITS);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic                  slot_start, show, show_next, slot_end;
  logic [IW-1:0]         idx;
  logic [FW-1:0]         active_bcd, pend_bcd;
  logic                  pend_valid;
  logic [NUM_DIGITS-1:0] lz_mask;
  logic                  all_zero;
  logic [3:0]            cur_nibble, slot_code;

  seg_slot_timer #(
    .CLK_DIV      (CLK_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .slot_start (slot_start),
    .show       (show),
    .show_next  (show_next),
    .slot_end   (slot_end)
  );

  assign load_ready = !pend_valid;
  assign frame_done = slot_end && (idx == IDX_LAST);
  assign seg_out    = show ? dec_seg : SEG_OFF;

  // Digit i is a leading zero when it and every more significant digit are 0.
  always_comb begin
    lz_mask  = '0;
    all_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      all_zero   = all_zero && (active_bcd[4*i +: 4] == 4'h0);
      lz_mask[i] = all_zero;
    end
  end

  always_comb begin
    cur_nibble = active_bcd[4*idx +: 4];
    slot_code  = (blank_lz && lz_mask[idx]) ? BLANK_CODE : cur_nibble;
  end

  // dec_bcd is loaded on the first BLANK cycle so the decoder settles before SHOW;
  // digit_en follows the timer's next state so it is registered yet aligned with show.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      dec_bcd  <= BLANK_CODE;
      digit_en <= '0;
    end else begin
      if (slot_end)   idx     <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
      if (slot_start) dec_bcd <= slot_code;
      digit_en <= show_next ? (NUM_DIGITS'(1) << idx) : '0;
    end
  end

  // Active only changes at the frame boundary, so a frame is never shown torn.
  // NOTE: pend_bcd is reset even though pend_valid alone qualifies it, keeping
  // the datapath free of X after reset at the cost of a few reset connections.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_bcd <= '0;
      pend_bcd   <= '0;
      pend_valid <= 1'b0;
    end else if (frame_done && pend_valid) begin
      active_bcd <= pend_bcd;
      pend_valid <= 1'b0;
    end else if (load_valid && load_ready) begin
      pend_bcd   <= load_bcd;
      pend_valid <= 1'b1;
    end
  end

endmodule
